bench_bist: RTL and testbench

BENCH_BIST -- requirements
Module: bench_bist

---
 rtl/bench_bist.sv | 150 +++++++++++++++
 tb/tb_bench_bist.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bench_bist.sv
// bench_bist: small combinational core with a registered functional path and
// a self-test controller (LFSR pattern source, MISR response compactor).
module bench_bist #(
    parameter int unsigned     IN_W  = 60,
    parameter int unsigned     OUT_W = 26,
    parameter int unsigned     CNT_W = 16,
    parameter logic [IN_W-1:0] SEED  = IN_W'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] signature
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [IN_W-1:0]  lfsr;
    logic [OUT_W-1:0] misr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] last_idx;

    logic accept;
    logic step;
    logic clear;

    logic [OUT_W-1:0] f_in;
    logic [OUT_W-1:0] f_lfsr;

    // High input bits beyond the core's reach are intentionally ignored.
    logic unused_in_bits;
    assign unused_in_bits = ^in;

    // Core function, one copy for the functional operand and one for the LFSR.
    assign f_in[0]   = in[0] & in[1];
    assign f_in[1]   = in[0] | in[1];
    assign f_lfsr[0] = lfsr[0] & lfsr[1];
    assign f_lfsr[1] = lfsr[0] | lfsr[1];

    genvar g;
    for (g = 2; g < OUT_W; g++) begin : g_core
        assign f_in[g]   = ~in[g % IN_W];
        assign f_lfsr[g] = ~lfsr[g % IN_W];
    end

    assign last_idx = n_reg - CNT_ONE;

    // Functional path: registered result, frozen while in BIST mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (!mode) begin
            out       <= f_in;
            out_valid <= in_valid;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // BIST state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        clear    = 1'b0;
        case (state)
            IDLE: begin
                if (mode && start) begin
                    accept   = 1'b1;
                    state_nx = (num_patterns == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!mode) begin
                    clear    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == last_idx) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (!mode) begin
                    clear    = 1'b1;
                    state_nx = IDLE;
                end else if (start) begin
                    accept   = 1'b1;
                    state_nx = (num_patterns == '0) ? DONE : RUN;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Pattern generator, signature register and pattern counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr  <= SEED;
            misr  <= '0;
            cnt   <= '0;
            n_reg <= '0;
        end else if (accept) begin
            lfsr  <= SEED;
            misr  <= '0;
            cnt   <= '0;
            n_reg <= num_patterns;
        end else if (step) begin
            misr <= {misr[OUT_W-2:0], misr[OUT_W-1]} ^ f_lfsr;
            lfsr <= {lfsr[IN_W-2:0], lfsr[IN_W-1] ^ lfsr[0]};
            cnt  <= cnt + CNT_ONE;
        end else if (clear) begin
            misr <= '0;
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign signature = misr;

endmodule

// File: tb/tb_bench_bist.sv
// tb_bench_bist: directed checks on a 4/4 instance plus random functional
// checks on a default-parameter instance.
module tb_bench_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance (IN_W=4, OUT_W=4, SEED=1)
    logic       rst_n;
    logic       mode;
    logic [3:0] in;
    logic       in_valid;
    logic       start;
    logic [7:0] num_patterns;
    logic [3:0] out;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [3:0] signature;

    bench_bist #(
        .IN_W (4),
        .OUT_W(4),
        .CNT_W(8),
        .SEED (4'b0001)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .in          (in),
        .in_valid    (in_valid),
        .start       (start),
        .num_patterns(num_patterns),
        .out         (out),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done),
        .signature   (signature)
    );

    // Default-parameter instance (60/26)
    logic [59:0] b_in;
    logic        b_in_valid;
    logic [15:0] b_num;
    logic [25:0] b_out;
    logic        b_out_valid;
    logic        b_busy;
    logic        b_done;
    logic [25:0] b_sig;

    bench_bist dut_big (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (1'b0),
        .in          (b_in),
        .in_valid    (b_in_valid),
        .start       (1'b0),
        .num_patterns(b_num),
        .out         (b_out),
        .out_valid   (b_out_valid),
        .busy        (b_busy),
        .done        (b_done),
        .signature   (b_sig)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [25:0] f_model(input logic [59:0] x);
        logic [25:0] r;
        r[0] = x[0] & x[1];
        r[1] = x[0] | x[1];
        for (int i = 2; i < 26; i++) r[i] = ~x[i % 60];
        return r;
    endfunction

    typedef struct {
        logic [3:0] vin;
        logic       vvalid;
        logic [3:0] exp_out;
        logic       exp_valid;
    } fvec_t;

    typedef struct {
        logic [7:0] n;
        logic [3:0] exp_sig;
    } bvec_t;

    // Start a run from the current state and wait (bounded) for done.
    task automatic run_bist(input logic [7:0] n, input logic [3:0] exp_sig, input string tag);
        int busy_cycles;
        bit got_done;
        busy_cycles = 0;
        got_done    = 0;
        @(negedge clk);
        mode = 1'b1; start = 1'b1; num_patterns = n;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < int'(n) + 5; k++) begin
            if (done) begin
                got_done = 1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        check({tag, "_done"}, 64'(got_done), 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(n));
        check({tag, "_sig"}, 64'(signature), 64'(exp_sig));
    endtask

    fvec_t fv[6];
    bvec_t bv[5];

    initial begin
        fv[0] = '{4'b0001, 1'b1, 4'b1110, 1'b1};
        fv[1] = '{4'b0000, 1'b1, 4'b1100, 1'b1};
        fv[2] = '{4'b1111, 1'b1, 4'b0011, 1'b1};
        fv[3] = '{4'b0110, 1'b1, 4'b1010, 1'b1};
        fv[4] = '{4'b1011, 1'b1, 4'b0111, 1'b1};
        fv[5] = '{4'b0001, 1'b0, 4'b1110, 1'b0};

        bv[0] = '{8'd2, 4'h2};
        bv[1] = '{8'd0, 4'h0};
        bv[2] = '{8'd1, 4'hE};
        bv[3] = '{8'd3, 4'hF};
        bv[4] = '{8'd4, 4'hC};

        rst_n = 1'b0; mode = 1'b0; in = '0; in_valid = 1'b0;
        start = 1'b0; num_patterns = '0;
        b_in = '0; b_in_valid = 1'b0; b_num = '0;

        // Reset state
        #12;
        check("rst_out", 64'(out), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sig", 64'(signature), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Functional path, 1-cycle latency
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in = fv[i].vin; in_valid = fv[i].vvalid;
            @(negedge clk);
            check($sformatf("func%0d_out", i), 64'(out), 64'(fv[i].exp_out));
            check($sformatf("func%0d_valid", i), 64'(out_valid), 64'(fv[i].exp_valid));
        end

        // BIST run table (each run starts from IDLE or DONE)
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_bist(bv[i].n, bv[i].exp_sig, $sformatf("bist_n%0d", bv[i].n));
        end
        check("bist_out_valid_gated", 64'(out_valid), 64'd0);
        check("bist_out_held", 64'(out), 64'hE);

        // DONE holds over idle cycles
        repeat (3) @(negedge clk);
        check("done_hold", 64'(done), 64'd1);
        check("done_hold_sig", 64'(signature), 64'hC);

        // Start pulsed mid-RUN is ignored
        @(negedge clk);
        start = 1'b1; num_patterns = 8'd2;
        @(negedge clk);
        check("mid_start_busy", 64'(busy), 64'd1);
        num_patterns = 8'd5;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_busy2", 64'(busy), 64'd1);
        @(negedge clk);
        check("mid_start_done", 64'(done), 64'd1);
        check("mid_start_sig", 64'(signature), 64'h2);

        // Mode dropped during RUN
        @(negedge clk);
        start = 1'b1; num_patterns = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mdrop_partial_sig", 64'(signature), 64'hE);
        mode = 1'b0;
        @(negedge clk);
        check("mdrop_busy", 64'(busy), 64'd0);
        check("mdrop_done", 64'(done), 64'd0);
        check("mdrop_sig", 64'(signature), 64'd0);

        // Mode dropped in DONE
        run_bist(8'd2, 4'h2, "pre_ddrop");
        mode = 1'b0;
        @(negedge clk);
        check("ddrop_done", 64'(done), 64'd0);
        check("ddrop_sig", 64'(signature), 64'd0);

        // Asynchronous reset mid-RUN
        in = 4'b0001; in_valid = 1'b1;
        @(negedge clk);
        mode = 1'b1; start = 1'b1; num_patterns = 8'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", 64'(out), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_sig", 64'(signature), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);
        check("post_rst_sig", 64'(signature), 64'd0);
        run_bist(8'd2, 4'h2, "post_rst_run");
        mode = 1'b0;

        // Default-parameter functional path against the model
        for (int i = 0; i < 20; i++) begin
            logic [59:0] v;
            logic        vv;
            @(negedge clk);
            v  = {28'($urandom), $urandom};
            vv = 1'($urandom_range(0, 1));
            b_in = v; b_in_valid = vv;
            @(negedge clk);
            check($sformatf("big%0d_out", i), 64'(b_out), 64'(f_model(v)));
            check($sformatf("big%0d_valid", i), 64'(b_out_valid), 64'(vv));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
